// File: rtl/lane_packer_if.sv
// Stream bundle around the lane packer: serial value input, packed word output.
interface lane_packer_if #(
  parameter int NUM      = 4,
  parameter int bitwidth = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [bitwidth-1:0]     in_data;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [NUM*bitwidth-1:0] out_data;
  logic [NUM-1:0]          out_ctr;
  logic                    out_last;

  // Environment side: feeds values and consumes packed words.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_ctr, out_last
  );

  // Packer side.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_ctr, out_last
  );
endinterface

// File: rtl/lane_packer.sv
// Packs a serial stream of values into NUM-lane words with a contiguous lane
// enable mask. A word closes when the last lane fills or the group ends; if
// the output register is busy, the closed word waits in the assembly register
// (pending) and input is held off until it can move on.
module lane_packer #(
  parameter int NUM      = 4,
  parameter int bitwidth = 16
) (
  input logic         clk,
  input logic         rst,
  lane_packer_if.slave bus
);
  localparam int             FW        = $clog2(NUM);
  localparam logic [FW-1:0]  LAST_LANE = FW'(NUM - 1);

  logic [NUM*bitwidth-1:0] asm_data;
  logic [NUM-1:0]          asm_mask;
  logic                    asm_last;
  logic [FW-1:0]           fill;
  logic                    pending;

  logic [NUM*bitwidth-1:0] out_data_r;
  logic [NUM-1:0]          out_ctr_r;
  logic                    out_last_r;
  logic                    out_valid_r;

  logic [NUM*bitwidth-1:0] word_data;
  logic [NUM-1:0]          word_mask;
  logic                    accept;
  logic                    slot_free;
  logic                    closing;

  // in_ready depends only on held state and reset, never on out_ready.
  assign bus.in_ready = ~pending & ~rst;
  assign accept       = bus.in_valid & bus.in_ready;
  assign slot_free    = ~out_valid_r | bus.out_ready;
  assign closing      = accept & ((fill == LAST_LANE) | bus.in_last);

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_ctr   = out_ctr_r;
  assign bus.out_last  = out_last_r;

  // Assembly word with the incoming value merged into lane 'fill'.
  always_comb begin
    word_data = asm_data;
    word_mask = asm_mask;
    for (int i = 0; i < NUM; i++) begin
      if (fill == FW'(i)) begin
        word_data[i*bitwidth +: bitwidth] = bus.in_data;
        word_mask[i]                      = 1'b1;
      end
    end
  end

  // Assembly, pending hand-off and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_data    <= '0;
      asm_mask    <= '0;
      asm_last    <= 1'b0;
      fill        <= '0;
      pending     <= 1'b0;
      out_data_r  <= '0;
      out_ctr_r   <= '0;
      out_last_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      if (out_valid_r && bus.out_ready) begin
        out_valid_r <= 1'b0;
      end

      if (pending) begin
        if (slot_free) begin
          out_data_r  <= asm_data;
          out_ctr_r   <= asm_mask;
          out_last_r  <= asm_last;
          out_valid_r <= 1'b1;
          asm_data    <= '0;
          asm_mask    <= '0;
          asm_last    <= 1'b0;
          pending     <= 1'b0;
        end
      end else if (accept) begin
        if (closing) begin
          fill <= '0;
          if (slot_free) begin
            out_data_r  <= word_data;
            out_ctr_r   <= word_mask;
            out_last_r  <= bus.in_last;
            out_valid_r <= 1'b1;
            asm_data    <= '0;
            asm_mask    <= '0;
            asm_last    <= 1'b0;
          end else begin
            // Closed word parks here until the output register frees up.
            asm_data <= word_data;
            asm_mask <= word_mask;
            asm_last <= bus.in_last;
            pending  <= 1'b1;
          end
        end else begin
          asm_data <= word_data;
          asm_mask <= word_mask;
          fill     <= fill + FW'(1);
        end
      end
    end
  end
endmodule

// File: doc/lane_packer.md
# lane_packer

Upstream feeder for the masked lane adder. It accepts a serial stream of `bitwidth`-wide neighbour values with a valid/ready handshake and a per-group `last` flag. It packs the values into `NUM`-lane words and emits each word with a per-lane enable mask (`out_ctr`) that the adder uses to gate its lanes. Partial words at group end are padded with zero data and a cleared mask bit, so the adder's masked sum is always exact.

## Interface
- `NUM`, default 4: lanes per output word; must be ≥ 2.
- `bitwidth`, default 16: width of one value.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset; one clock; synchronous and active-high.
- `in_valid` in 1: input value present.
- `in_ready` out 1: block accepts the input this cycle.
- `in_data` in `bitwidth`: input value.
- `in_last` in 1: final value of the current group.
- `out_valid` out 1: output word present.
- `out_ready` in 1: consumer accepts the output this cycle.
- `out_data` out `NUM*bitwidth`: packed word; lane i occupies bits `[i*bitwidth +: bitwidth]`.
- `out_ctr` out `NUM`: lane enable mask; bit i=1 means lane i holds a valid value.
- `out_last` out 1: this word closes a group.

## Operation
- **Handshakes.** An input accepts on `in_valid & in_ready`. An output transfers on `out_valid & out_ready`.
- **Internal state.**
  - Assembly register: data, mask, last.
  - `fill` counter: 0..NUM-1, the next lane to write.
  - Output register: data, ctr, last, valid.
  - `pending` flag.
- **Accepted value.** It is written to lane `fill`, and mask bit `fill` is set.
  - The value is a *closing item* if `fill == NUM-1` or `in_last` is 1. Otherwise `fill` increments.
- **Closing item, output slot free.** The slot is free when `out_valid` is 0 or the output transfers this cycle.
  - The completed word (including the closing item) loads the output register.
  - `out_last` is set to `in_last`.
  - The assembly register clears: data 0, mask 0, `fill` 0.
- **Closing item, output slot occupied and not transferring.**
  - The word stays in the assembly register and `pending` is set.
- **While `pending` is 1.**
  - `in_ready` is 0.
  - On the first cycle the output slot is free, the assembly word moves to the output register, the assembly clears, and `pending` clears.
- **`in_ready`** equals `~pending & ~rst`. It is a registered-state function with no combinational path from `out_ready` or `in_valid`.
- **Unused lanes.** Lanes with mask bit 0 always carry data 0.
- **Mask shape.** `out_ctr` is always contiguous from lane 0, i.e. of the form 2^k − 1 with 1 ≤ k ≤ NUM. A word with an all-zero mask is never emitted.
- **Ignored inputs.** `in_last` is ignored when the value is not accepted. An idle stream produces no output, and there is no timeout flush.
- **Output stability.** While `out_valid=1` and `out_ready=0`, the values of `out_data`, `out_ctr` and `out_last` are stable.

## Timing
- **Reset.** While `rst=1`, on each rising edge:
  - `out_valid`=0, `out_data`=0, `out_ctr`=0, `out_last`=0.
  - `pending`=0, `fill`=0, and the assembly register clears.
  - `in_ready`=0 while `rst` is high and 1 in the first cycle after it deasserts.
- **Reset mid-operation.** Partial and pending words are discarded; nothing is flushed.
- **Latency.** A closing item accepted in cycle T (free slot) gives `out_valid`=1 in cycle T+1.
- **Throughput.** With `out_ready` held 1, the block sustains one input per cycle. One word is emitted every NUM inputs, or earlier at `in_last`.
- **Simultaneous events.** A closing item on the same cycle as an output transfer reloads the output register with no bubble. `out_valid` stays 1.
- **Backpressure capacity.** With `out_ready`=0 the block holds at most one word in the output register plus one pending word. `in_ready` drops in the cycle after the second word closes.
- **Pending release.** A pending word moves on the edge of the transfer that frees the slot. It is visible in the next cycle, and `in_ready` returns to 1 in that same next cycle.

## Test plan
- **Full word with group close.** NUM=4, bitwidth=16, `out_ready`=1. Send 1, 2, 3, 4 with `in_last` on 4.
  - Expect one word: `out_data`=0x0004_0003_0002_0001, `out_ctr`=4'b1111, `out_last`=1, `out_valid` in the cycle after 4 is accepted.
- **Partial word.** Send 5, 6 with `in_last` on 6.
  - Expect `out_data`=0x0000_0000_0006_0005, `out_ctr`=4'b0011, `out_last`=1.
- **Group of 6 back-to-back.** Send 10..15 with `in_last` on 15, `out_ready`=1.
  - Expect two words: `out_ctr`=1111 with `out_last`=0, then `out_ctr`=0011 with `out_last`=1.
  - `in_ready` stays 1 throughout.
- **Backpressure.** Hold `out_ready`=0 and stream 12 values.
  - `in_ready` falls after the 8th value is accepted.
  - Raise `out_ready` and expect words {1..4}, {5..8}, {9..12} in order, with no loss or duplication and stable outputs while stalled.
- **Reset mid-word.** Assert `rst` for one cycle after 2 of 4 values.
  - Expect all outputs 0 and no word emitted.
  - The next 4 values produce a word starting at lane 0.
- **Single-item group.** Send 0xFFFF with `in_last`.
  - Expect `out_ctr`=4'b0001, lanes 1–3 = 0, `out_last`=1.
